uart_hamming_rx: RTL and testbench

UART_HAMMING_RX -- requirements
Module: uart_hamming_rx

---
 rtl/uart_hamming_pkg.sv | 30 +++
 rtl/hamming12_decoder.sv | 42 ++++
 rtl/uart_hamming_rx.sv | 137 +++++++++++++
 tb/tb_uart_hamming_rx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_hamming_pkg.sv
// Shared constants, FSM states and codeword bit positions for the Hamming(12,8) UART receiver.
package uart_hamming_pkg;

    localparam int unsigned CYCLES_PER_BIT_DEFAULT = 868;
    localparam int unsigned FRAME_BITS             = 12;
    localparam int unsigned SYN_MAX_CORRECTABLE    = 12;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StDone
    } rx_state_e;

    // Bit index of each field; Hamming position n lives at bit n-1.
    localparam int unsigned P1_BIT = 0;
    localparam int unsigned P2_BIT = 1;
    localparam int unsigned D0_BIT = 2;
    localparam int unsigned P4_BIT = 3;
    localparam int unsigned D1_BIT = 4;
    localparam int unsigned D2_BIT = 5;
    localparam int unsigned D3_BIT = 6;
    localparam int unsigned P8_BIT = 7;
    localparam int unsigned D4_BIT = 8;
    localparam int unsigned D5_BIT = 9;
    localparam int unsigned D6_BIT = 10;
    localparam int unsigned D7_BIT = 11;

endpackage

// File: rtl/hamming12_decoder.sv
// Combinational Hamming(12,8) decoder: syndrome, single-bit correction, data extraction.
module hamming12_decoder
    import uart_hamming_pkg::*;
(
    input  logic [FRAME_BITS-1:0] codeword_i,
    output logic [7:0]            data_o,
    output logic [3:0]            syndrome_o,
    output logic                  corrected_o,
    output logic                  uncorrectable_o
);

    logic [3:0]            syn;
    logic [FRAME_BITS-1:0] fixed;
    logic [FRAME_BITS-1:0] flip_mask;

    always_comb begin
        syn[0] = codeword_i[P1_BIT] ^ codeword_i[D0_BIT] ^ codeword_i[D1_BIT] ^
                 codeword_i[D3_BIT] ^ codeword_i[D4_BIT] ^ codeword_i[D6_BIT];
        syn[1] = codeword_i[P2_BIT] ^ codeword_i[D0_BIT] ^ codeword_i[D2_BIT] ^
                 codeword_i[D3_BIT] ^ codeword_i[D5_BIT] ^ codeword_i[D6_BIT];
        syn[2] = codeword_i[P4_BIT] ^ codeword_i[D1_BIT] ^ codeword_i[D2_BIT] ^
                 codeword_i[D3_BIT] ^ codeword_i[D7_BIT];
        syn[3] = codeword_i[P8_BIT] ^ codeword_i[D4_BIT] ^ codeword_i[D5_BIT] ^
                 codeword_i[D6_BIT] ^ codeword_i[D7_BIT];

        flip_mask       = {{(FRAME_BITS-1){1'b0}}, 1'b1} << (syn - 4'd1);
        fixed           = codeword_i;
        corrected_o     = 1'b0;
        uncorrectable_o = 1'b0;
        if (32'(syn) > SYN_MAX_CORRECTABLE) begin
            uncorrectable_o = 1'b1;
        end else if (syn != 4'd0) begin
            fixed       = codeword_i ^ flip_mask;
            corrected_o = 1'b1;
        end

        syndrome_o = syn;
        data_o     = {fixed[D7_BIT], fixed[D6_BIT], fixed[D5_BIT], fixed[D4_BIT],
                      fixed[D3_BIT], fixed[D2_BIT], fixed[D1_BIT], fixed[D0_BIT]};
    end

endmodule

// File: rtl/uart_hamming_rx.sv
// UART receiver for 12-bit Hamming-coded frames (start, 12 bits MSB first, stop).
// Reports the corrected byte with error flags as a one-cycle data_valid pulse.
module uart_hamming_rx
    import uart_hamming_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BIT = CYCLES_PER_BIT_DEFAULT,
    parameter int unsigned SAMPLE_POINT   = CYCLES_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       err_corrected,
    output logic       err_uncorrectable,
    output logic       err_frame,
    output logic [3:0] syndrome,
    output logic       busy
);

    localparam int unsigned CNT_W     = $clog2(CYCLES_PER_BIT);
    localparam int unsigned BIT_CNT_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0]     BIT_LAST    = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0]     SAMPLE_LAST = CNT_W'(SAMPLE_POINT - 1);
    localparam logic [BIT_CNT_W-1:0] FRAME_LAST  = BIT_CNT_W'(FRAME_BITS - 1);

    rx_state_e             state_q;
    logic                  rx_meta_q, rx_s_q, rx_prev_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [7:0]            data_out_q;
    logic [3:0]            syndrome_q;
    logic                  data_valid_q, err_corrected_q, err_uncorrectable_q, err_frame_q;

    logic [7:0] dec_data;
    logic [3:0] dec_syndrome;
    logic       dec_corrected, dec_uncorrectable;

    hamming12_decoder u_decoder (
        .codeword_i      (shift_q),
        .data_o          (dec_data),
        .syndrome_o      (dec_syndrome),
        .corrected_o     (dec_corrected),
        .uncorrectable_o (dec_uncorrectable)
    );

    // Synchronizer and edge history reset to idle-high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= serial_in;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= StIdle;
            cnt_q               <= '0;
            bit_cnt_q           <= '0;
            shift_q             <= '0;
            data_out_q          <= '0;
            syndrome_q          <= '0;
            data_valid_q        <= 1'b0;
            err_corrected_q     <= 1'b0;
            err_uncorrectable_q <= 1'b0;
            err_frame_q         <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q     <= '0;
                    bit_cnt_q <= '0;
                    // Needs a 1->0 transition, so a line stuck low after a bad stop bit waits.
                    if (rx_prev_q && !rx_s_q) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (cnt_q == SAMPLE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= rx_s_q ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {shift_q[FRAME_BITS-2:0], rx_s_q};
                        if (bit_cnt_q == FRAME_LAST) begin
                            state_q <= StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q               <= '0;
                        state_q             <= StDone;
                        data_valid_q        <= 1'b1;
                        data_out_q          <= dec_data;
                        syndrome_q          <= dec_syndrome;
                        err_corrected_q     <= dec_corrected;
                        err_uncorrectable_q <= dec_uncorrectable;
                        err_frame_q         <= ~rx_s_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign data_out          = data_out_q;
    assign data_valid        = data_valid_q;
    assign err_corrected     = err_corrected_q;
    assign err_uncorrectable = err_uncorrectable_q;
    assign err_frame         = err_frame_q;
    assign syndrome          = syndrome_q;
    assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_uart_hamming_rx.sv
// Directed bench for uart_hamming_rx: table of coded frames plus glitch, reset, framing
// and back-to-back sequences.
module tb_uart_hamming_rx;

    localparam int unsigned CPB = 240;
    localparam int unsigned SP  = CPB / 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       err_corrected;
    logic       err_uncorrectable;
    logic       err_frame;
    logic [3:0] syndrome;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] pulse_data[$];
    int         pulse_cyc[$];

    uart_hamming_rx #(
        .CYCLES_PER_BIT (CPB),
        .SAMPLE_POINT   (SP)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .serial_in         (serial_in),
        .data_out          (data_out),
        .data_valid        (data_valid),
        .err_corrected     (err_corrected),
        .err_uncorrectable (err_uncorrectable),
        .err_frame         (err_frame),
        .syndrome          (syndrome),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            pulse_data.push_back(data_out);
            pulse_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Call right after a negedge; returns at the end of the stop bit with the line high.
    task automatic send_frame(input logic [11:0] cw, input logic stop_bit);
        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 11; i >= 0; i--) begin
            serial_in = cw[i];
            repeat (CPB) @(negedge clk);
        end
        serial_in = stop_bit;
        repeat (CPB) @(negedge clk);
        serial_in = 1'b1;
    endtask

    typedef struct {
        logic [11:0] cw;
        logic [7:0]  data;
        logic [3:0]  syn;
        logic        corr;
        logic        unc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int         base;
        logic [11:0] cw_rst;

        vecs[0] = '{12'hA27, 8'hA5, 4'd0,  1'b0, 1'b0};
        vecs[1] = '{12'hA37, 8'hA5, 4'd5,  1'b1, 1'b0};
        vecs[2] = '{12'h362, 8'h3C, 4'd0,  1'b0, 1'b0};
        vecs[3] = '{12'h366, 8'h3C, 4'd3,  1'b1, 1'b0};
        vecs[4] = '{12'hA26, 8'hA5, 4'd1,  1'b1, 1'b0};
        vecs[5] = '{12'h227, 8'hA5, 4'd12, 1'b1, 1'b0};
        vecs[6] = '{12'h226, 8'h25, 4'd13, 1'b0, 1'b1};
        vecs[7] = '{12'h225, 8'h25, 4'd14, 1'b0, 1'b1};
        vecs[8] = '{12'h223, 8'h24, 4'd15, 1'b0, 1'b1};

        reset     = 1'b1;
        serial_in = 1'b1;
        repeat (4) @(negedge clk);
        check("reset data_out", 32'(data_out), 32'h0);
        check("reset data_valid", 32'(data_valid), 32'h0);
        check("reset syndrome", 32'(syndrome), 32'h0);
        check("reset flags", 32'({err_corrected, err_uncorrectable, err_frame}), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            base = pulse_data.size();
            send_frame(vecs[v].cw, 1'b1);
            repeat (CPB) @(negedge clk);
            check($sformatf("vec%0d pulses", v), 32'(pulse_data.size()), 32'(base + 1));
            check($sformatf("vec%0d data", v), 32'(data_out), 32'(vecs[v].data));
            check($sformatf("vec%0d syndrome", v), 32'(syndrome), 32'(vecs[v].syn));
            check($sformatf("vec%0d corrected", v), 32'(err_corrected), 32'(vecs[v].corr));
            check($sformatf("vec%0d uncorrectable", v), 32'(err_uncorrectable), 32'(vecs[v].unc));
            check($sformatf("vec%0d frame", v), 32'(err_frame), 32'h0);
            check($sformatf("vec%0d busy idle", v), 32'(busy), 32'h0);
        end

        // 100-cycle low glitch must be rejected at the start-bit sample point.
        base = pulse_data.size();
        serial_in = 1'b0;
        for (int n = 1; n <= int'(SP) + 3; n++) begin
            @(negedge clk);
            if (n == 100) serial_in = 1'b1;
            if (n == 3) check("glitch busy rises", 32'(busy), 32'h1);
            if (n == int'(SP) + 2) check("glitch busy before sample", 32'(busy), 32'h1);
            if (n == int'(SP) + 3) check("glitch busy after sample", 32'(busy), 32'h0);
        end
        repeat (2 * CPB) @(negedge clk);
        check("glitch no pulse", 32'(pulse_data.size()), 32'(base));

        // Reset in the middle of the 6th data bit, then a clean 0x3C frame.
        base   = pulse_data.size();
        cw_rst = 12'hA27;
        serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 11; i >= 6; i--) begin
            serial_in = cw_rst[i];
            repeat ((i == 6) ? CPB / 2 : CPB) @(negedge clk);
        end
        check("midframe busy", 32'(busy), 32'h1);
        reset     = 1'b1;
        serial_in = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset busy", 32'(busy), 32'h0);
        check("midreset data_out", 32'(data_out), 32'h0);
        check("midreset syndrome", 32'(syndrome), 32'h0);
        check("midreset flags", 32'({err_corrected, err_uncorrectable, err_frame}), 32'h0);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        send_frame(12'h362, 1'b1);
        repeat (CPB) @(negedge clk);
        check("post-reset pulses", 32'(pulse_data.size()), 32'(base + 1));
        check("post-reset data", 32'(data_out), 32'h3C);
        check("post-reset flags", 32'({err_corrected, err_uncorrectable, err_frame}), 32'h0);

        // Framing error with the line left low afterwards.
        base = pulse_data.size();
        send_frame(12'hA27, 1'b0);
        serial_in = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        check("frame err pulses", 32'(pulse_data.size()), 32'(base + 1));
        check("frame err flag", 32'(err_frame), 32'h1);
        check("frame err data", 32'(data_out), 32'hA5);
        check("frame err syndrome", 32'(syndrome), 32'h0);
        for (int b = 0; b < 3; b++) begin
            repeat (CPB) @(negedge clk);
            check($sformatf("line low busy%0d", b), 32'(busy), 32'h0);
        end
        check("line low no pulse", 32'(pulse_data.size()), 32'(base + 1));
        serial_in = 1'b1;
        repeat (CPB) @(negedge clk);

        // Back-to-back frames, one stop bit each.
        base = pulse_data.size();
        send_frame(12'h000, 1'b1);
        send_frame(12'hF77, 1'b1);
        repeat (CPB) @(negedge clk);
        check("b2b pulses", 32'(pulse_data.size()), 32'(base + 2));
        if (pulse_data.size() == base + 2) begin
            check("b2b first data", 32'(pulse_data[base]), 32'h00);
            check("b2b second data", 32'(pulse_data[base + 1]), 32'hFF);
            check("b2b spacing ok",
                  32'((pulse_cyc[base + 1] - pulse_cyc[base] >= int'(CPB * 14) - 2) &&
                      (pulse_cyc[base + 1] - pulse_cyc[base] <= int'(CPB * 14) + 2)), 32'h1);
        end
        check("b2b flags", 32'({err_corrected, err_uncorrectable, err_frame}), 32'h0);
        check("b2b syndrome", 32'(syndrome), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
